// File: rtl/input_conditioner.sv
// input_conditioner: synchronises the raw asynchronous D input into the Clock
// domain and debounces it. The outputs are a clean level Q, one-cycle
// Rise/Fall/Glitch pulses, and a wrapping count of accepted edges.
// D only ever reaches the first synchroniser flop. Any metastability is held
// there, and nothing downstream is driven combinationally from D.

module input_conditioner #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 D,
    output logic                 Q,
    output logic                 Rise,
    output logic                 Fall,
    output logic                 Glitch,
    output logic [CNT_WIDTH-1:0] EdgeCount
);

    // The counter only needs to reach STABLE_CYCLES-1.
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    logic                 s1_r;
    logic                 s2_r;
    logic                 ds_s;
    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic                 q_r;
    logic                 rise_r;
    logic                 fall_r;
    logic                 glitch_r;
    logic [CNT_WIDTH-1:0] edge_count_r;

    assign ds_s = s2_r;

    // Two-flop synchroniser that brings D into the Clock domain.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= D;
            s2_r <= s1_r;
        end
    end

    // Debounce FSM. Q changes only after STABLE_CYCLES equal samples, and the pulses last one cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r      <= STABLE_LOW;
            cnt_r        <= '0;
            q_r          <= 1'b0;
            rise_r       <= 1'b0;
            fall_r       <= 1'b0;
            glitch_r     <= 1'b0;
            edge_count_r <= '0;
        end else begin
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
            glitch_r <= 1'b0;
            case (state_r)
                STABLE_LOW: begin
                    if (ds_s) begin
                        state_r <= CHECK_HIGH;
                        cnt_r   <= CW'(1);
                    end else begin
                        state_r <= STABLE_LOW;
                    end
                end
                CHECK_HIGH: begin
                    if (!ds_s) begin
                        state_r  <= STABLE_LOW;
                        glitch_r <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r      <= STABLE_HIGH;
                        q_r          <= 1'b1;
                        rise_r       <= 1'b1;
                        edge_count_r <= edge_count_r + CNT_WIDTH'(1);
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!ds_s) begin
                        state_r <= CHECK_LOW;
                        cnt_r   <= CW'(1);
                    end else begin
                        state_r <= STABLE_HIGH;
                    end
                end
                CHECK_LOW: begin
                    if (ds_s) begin
                        state_r  <= STABLE_HIGH;
                        glitch_r <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r      <= STABLE_LOW;
                        q_r          <= 1'b0;
                        fall_r       <= 1'b1;
                        edge_count_r <= edge_count_r + CNT_WIDTH'(1);
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    // Recover to the stable state that matches the level currently driven on Q.
                    state_r <= q_r ? STABLE_HIGH : STABLE_LOW;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign Q         = q_r;
    assign Rise      = rise_r;
    assign Fall      = fall_r;
    assign Glitch    = glitch_r;
    assign EdgeCount = edge_count_r;

endmodule
